// File: rtl/calc_entry_seq_if.sv
// Bus between the calculator entry sequencer, its switch/button inputs and the ALU.
// slave: the sequencer side; master: the environment (switches, buttons, ALU).
interface calc_entry_seq_if #(
  parameter int W   = 12,
  parameter int OPW = 4
);
  logic [W-1:0]   din;
  logic           btn_enter;
  logic           btn_clear;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_s;
  logic [W-1:0]   alu_o;
  logic           alu_err;
  logic           alu_l;
  logic           alu_ovf;
  logic [W-1:0]   res;
  logic           res_err;
  logic           res_l;
  logic           res_ovf;
  logic           res_valid;
  logic [2:0]     state;

  modport slave (
    input  din, btn_enter, btn_clear, alu_o, alu_err, alu_l, alu_ovf,
    output alu_a, alu_b, alu_s, res, res_err, res_l, res_ovf, res_valid, state
  );

  modport master (
    output din, btn_enter, btn_clear, alu_o, alu_err, alu_l, alu_ovf,
    input  alu_a, alu_b, alu_s, res, res_err, res_l, res_ovf, res_valid, state
  );
endinterface

// File: rtl/calc_entry_seq.sv
// Operand/opcode entry sequencer in front of the calculator ALU; captures the ALU result.
// Optional macro CALC_ENTRY_ACCUM_EN: enter in SHOW feeds the result back as operand A.
module calc_entry_seq #(
  parameter int W   = 12,
  parameter int OPW = 4
) (
  input  logic              clk,
  input  logic              rst,
  calc_entry_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t         r_state;
  logic           r_btn_enter_q;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [OPW-1:0] r_alu_s;
  logic [W-1:0]   r_res;
  logic           r_res_err;
  logic           r_res_l;
  logic           r_res_ovf;
  logic           r_res_valid;
  logic           w_enter_pulse;

  assign w_enter_pulse = bus.btn_enter & ~r_btn_enter_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= LOAD_A;
      r_btn_enter_q <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_s       <= '0;
      r_res         <= '0;
      r_res_err     <= 1'b0;
      r_res_l       <= 1'b0;
      r_res_ovf     <= 1'b0;
      r_res_valid   <= 1'b0;
    end else begin
      r_btn_enter_q <= bus.btn_enter;
      // Clear outranks enter and also aborts a capture that is due this cycle.
      if (bus.btn_clear) begin
        r_state     <= LOAD_A;
        r_res_valid <= 1'b0;
      end else begin
        case (r_state)
          LOAD_A: begin
            if (w_enter_pulse) begin
              r_alu_a <= bus.din;
              r_state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (w_enter_pulse) begin
              r_alu_b <= bus.din;
              r_state <= LOAD_OP;
            end
          end
          LOAD_OP: begin
            if (w_enter_pulse) begin
              r_alu_s <= bus.din[OPW-1:0];
              r_state <= EXEC;
            end
          end
          EXEC: begin
            // ALU inputs have had one full cycle to settle.
            r_res       <= bus.alu_o;
            r_res_err   <= bus.alu_err;
            r_res_l     <= bus.alu_l;
            r_res_ovf   <= bus.alu_ovf;
            r_res_valid <= 1'b1;
            r_state     <= SHOW;
          end
          SHOW: begin
            if (w_enter_pulse) begin
              r_res_valid <= 1'b0;
`ifdef CALC_ENTRY_ACCUM_EN
              r_alu_a     <= r_res;
              r_state     <= LOAD_B;
`else
              r_state     <= LOAD_A;
`endif
            end
          end
          default: r_state <= LOAD_A;
        endcase
      end
    end
  end

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_s     = r_alu_s;
  assign bus.res       = r_res;
  assign bus.res_err   = r_res_err;
  assign bus.res_l     = r_res_l;
  assign bus.res_ovf   = r_res_ovf;
  assign bus.res_valid = r_res_valid;
  assign bus.state     = r_state;

endmodule

// File: doc/calc_entry_seq.md
Name: calc_entry_seq

Overview:
Operand/opcode entry sequencer that sits directly upstream of the 12-bit binary-calculator ALU and also captures what the ALU returns.
- Collects A, B and the 4-bit opcode one at a time from a shared 12-bit switch bus, each on an enter-button edge.
- Drives the ALU operand and opcode inputs from internal registers.
- After one settle cycle, registers the ALU result and flags for the display stage.

Parameters:
W, 12, operand/result width; must match the ALU width.
OPW, 4, opcode width; must match the ALU select width.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  W  switch bus; operand value, or opcode in din[OPW-1:0]
btn_enter  in  1  level from the debouncer; the block detects the rising edge itself
btn_clear  in  1  level; abort entry and return to LOAD_A
alu_a  out  W  registered operand A to the ALU
alu_b  out  W  registered operand B to the ALU
alu_s  out  OPW  registered opcode to the ALU
alu_o  in  W  ALU result
alu_err  in  1  ALU error flag
alu_l  in  1  ALU compare flag
alu_ovf  in  1  ALU over/underflow flag
res  out  W  captured result
res_err  out  1  captured error flag
res_l  out  1  captured compare flag
res_ovf  out  1  captured over/underflow flag
res_valid  out  1  high while res/flags hold a completed operation
state  out  3  current FSM state, for the display/LEDs

Behaviour:
- Reset (rst high at a clock edge):
  - state=LOAD_A (0).
  - alu_a=alu_b=0, alu_s=0, res=0, all res_* flags=0, res_valid=0.
  - Enter-edge history register cleared to 0.
- Edge detect:
  - enter_pulse = btn_enter & ~btn_enter_q, with btn_enter_q registered every cycle.
  - A held button produces exactly one pulse.
- States: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5–7 are unreachable and recover to LOAD_A on the next edge.
- LOAD_A: on enter_pulse, alu_a<=din, go to LOAD_B.
- LOAD_B: on enter_pulse, alu_b<=din, go to LOAD_OP.
- LOAD_OP: on enter_pulse, alu_s<=din[OPW-1:0], go to EXEC.
  - Opcodes 8–15 are forwarded unchanged; the result is whatever the ALU returns.
- EXEC: lasts exactly one cycle and ignores enter.
  - At its end: res<=alu_o, res_err<=alu_err, res_l<=alu_l, res_ovf<=alu_ovf, res_valid<=1, go to SHOW.
- SHOW: res/flags held stable.
  - On enter_pulse: res_valid<=0, go to LOAD_A. alu_a, alu_b and alu_s retain their values until overwritten.
- Latency: if the opcode enter edge is detected in cycle N, alu_s is valid from N+1 and res_valid is high from N+2.
- btn_clear, in any state:
  - Next state is LOAD_A and res_valid<=0.
  - Operand registers, res and flags keep their values.
  - Clear has priority over a simultaneous enter_pulse.
- rst has priority over everything, including mid-EXEC. A capture in progress is discarded.
- din is sampled only on the enter_pulse cycle; changes at other times have no effect.

Optional Feature:
Macro CALC_ENTRY_ACCUM_EN.
- Defined: in SHOW, enter_pulse loads alu_a<=res, clears res_valid and goes to LOAD_B. This chains results, e.g. running sums. btn_clear still returns to LOAD_A.
- Not defined: SHOW plus enter goes to LOAD_A as described above, with no feedback path from res.

Test Plan:
- Reset, then enter din=100, din=23, opcode 0 → alu_a=100, alu_b=23, alu_s=0; res=123, res_ovf=0, res_valid high exactly 2 cycles after the opcode edge.
- A=4000, B=200, op 0 → res=104, res_ovf=1. Then enter in SHOW → state=0, res_valid=0.
- A=5, B=9, op 6 → res_l=1, res=0. Op 7 on any operands → res_err=1.
- Hold btn_enter high for 10 cycles in LOAD_A → single transition to LOAD_B; alu_a equals din from the first cycle only.
- In LOAD_OP, assert btn_clear and btn_enter together → state=LOAD_A, alu_s unchanged. Assert rst during EXEC → all outputs 0 next cycle.
- With CALC_ENTRY_ACCUM_EN: 10+5 op 0 → 15. Enter in SHOW → state=LOAD_B, alu_a=15. B=7, op 0 → res=22.
